// File: rtl/vga_pixel_fetch.sv
// Line prefetcher for the VGA output path: reads packed pixel words for the next visible line,
// buffers them and unpacks one pixel per clock. Define VGA_FETCH_LINE_DOUBLE_EN to reuse each row twice.
module vga_pixel_fetch #(
    parameter int BPP    = 6,
    parameter int PPW    = 4,
    parameter int HACT   = 640,
    parameter int VACT   = 480,
    parameter int XMAX   = 799,
    parameter int YMAX   = 524,
    parameter int AWIDTH = 17,
    parameter int BASE   = 0,
    parameter int DEPTH  = 8
) (
    input  logic              PixelClkSrc,
    input  logic              Rst,
    input  logic [9:0]        PixelCounter,
    input  logic [9:0]        LineCounter,
    output logic              ReqValid,
    output logic [AWIDTH-1:0] ReqAddr,
    input  logic              ReqReady,
    input  logic              RspValid,
    input  logic [BPP*PPW-1:0] RspData,
    output logic [BPP-1:0]    PixColor,
    output logic              Underflow
);
    localparam int WW  = BPP * PPW;
    localparam int WPL = HACT / PPW;
    localparam int WCW = $clog2(WPL);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);

    localparam logic [9:0] HACT_C = 10'(HACT);
    localparam logic [9:0] VACT_C = 10'(VACT);
    localparam logic [9:0] XMAX_C = 10'(XMAX);
    localparam logic [9:0] YMAX_C = 10'(YMAX);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [WCW-1:0]    w_q, w_d;
    logic [AWIDTH-1:0] la_q, la_d;
    logic [CW-1:0]     out_q, out_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wp_q, wp_d;
    logic [PW-1:0]     rp_q, rp_d;
    logic [WW-1:0]     mem_q [DEPTH];
    logic [WW-1:0]     sreg_q, sreg_d;
    logic [BPP-1:0]    pix_q, pix_d;
    logic              unf_q, unf_d;

    logic [9:0]        tgt;
    logic              line_end, line_start, row_step, credit_ok;
    logic              acc, rsp, push, visible, need, pop;
    logic [WW-1:0]     head;

`ifdef VGA_FETCH_LINE_DOUBLE_EN
    assign row_step = ~tgt[0];
`else
    assign row_step = 1'b1;
`endif

    always_comb begin
        tgt        = (LineCounter == YMAX_C) ? 10'd0 : LineCounter + 10'd1;
        line_end   = PixelCounter == HACT_C;
        line_start = line_end && (tgt < VACT_C);
        credit_ok  = (32'(cnt_q) + 32'(out_q)) < 32'(DEPTH);
        ReqValid   = (state_q == S_FETCH) && credit_ok;
        acc        = ReqValid && ReqReady;
        // responses with nothing outstanding predate a reset
        rsp        = RspValid && (out_q != '0);
        push       = rsp && (drop_q == '0) && !line_end;
        visible    = (PixelCounter < HACT_C) && (LineCounter < VACT_C)
                     && (PixelCounter <= XMAX_C);
        need       = visible && ((32'(PixelCounter) % PPW) == 0);
        pop        = need && (cnt_q != '0);
        head       = mem_q[rp_q];
    end

    assign ReqAddr   = la_q + AWIDTH'(w_q);
    assign PixColor  = pix_q;
    assign Underflow = unf_q;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        la_d    = la_q;
        if (line_start) begin
            state_d = S_FETCH;
            w_d     = '0;
            if (tgt == 10'd0) la_d = AWIDTH'(BASE);
            else if (row_step) la_d = la_q + AWIDTH'(WPL);
        end else if (line_end) begin
            state_d = S_IDLE;
        end else if (acc) begin
            if (w_q == WCW'(WPL - 1)) state_d = S_IDLE;
            else w_d = w_q + WCW'(1);
        end
    end

    always_comb begin
        out_d = out_q;
        if (acc && !rsp) out_d = out_q + CW'(1);
        else if (!acc && rsp) out_d = out_q - CW'(1);
        // everything still in flight at line end belongs to the old line
        drop_d = drop_q;
        if (line_end) drop_d = out_d;
        else if (rsp && (drop_q != '0)) drop_d = drop_q - CW'(1);
        cnt_d = cnt_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (line_end) begin
            cnt_d = '0;
            wp_d  = '0;
            rp_d  = '0;
        end else begin
            if (push) wp_d = wp_q + PW'(1);
            if (pop) rp_d = rp_q + PW'(1);
            if (push && !pop) cnt_d = cnt_q + CW'(1);
            else if (!push && pop) cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        pix_d  = '0;
        sreg_d = sreg_q;
        unf_d  = unf_q;
        if (need) begin
            if (pop) begin
                pix_d  = head[BPP-1:0];
                sreg_d = head >> BPP;
            end else begin
                sreg_d = '0;
                unf_d  = 1'b1;
            end
        end else if (visible) begin
            pix_d  = sreg_q[BPP-1:0];
            sreg_d = sreg_q >> BPP;
        end
    end

    always_ff @(posedge PixelClkSrc) begin
        if (Rst) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            la_q    <= AWIDTH'(BASE);
            out_q   <= '0;
            drop_q  <= '0;
            cnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            sreg_q  <= '0;
            pix_q   <= '0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            la_q    <= la_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            sreg_q  <= sreg_d;
            pix_q   <= pix_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge PixelClkSrc) begin
        if (push) mem_q[wp_q] <= RspData;
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: random frame memory, in-order memory model with 2-cycle latency,
// pixel/address expectations derived from line and pixel numbers.
`timescale 1ns/1ps
module tb_vga_pixel_fetch;
    localparam int BPP   = 6;
    localparam int PPW   = 4;
    localparam int HACT  = 640;
    localparam int VACT  = 480;
    localparam int WPL   = HACT / PPW;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pc, lc;
    logic        req_valid;
    logic [16:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [23:0] rsp_data;
    logic [5:0]  pix;
    logic        unf;

    always #5 clk = ~clk;

    vga_pixel_fetch dut (
        .PixelClkSrc (clk),
        .Rst         (rst),
        .PixelCounter(pc),
        .LineCounter (lc),
        .ReqValid    (req_valid),
        .ReqAddr     (req_addr),
        .ReqReady    (req_ready),
        .RspValid    (rsp_valid),
        .RspData     (rsp_data),
        .PixColor    (pix),
        .Underflow   (unf)
    );

    int checks = 0;
    int failures = 0;
    logic [23:0] memw [0:1023];
    int pend_addr[$];
    int pend_due[$];
    int req_list[$];
    int cyc_n = 0;
    int rdy_mode = 0;
    bit mem_stall = 0;
    bit zero_mode = 0;
    bit chk_addr = 1;
    int line_acc = 0;
    int line_pops = 0;
    bit prev_stall = 0;
    logic [16:0] prev_addr = '0;
    int prev_pc = 0;

    function automatic int row_of(input int t);
`ifdef VGA_FETCH_LINE_DOUBLE_EN
        return t / 2;
`else
        return t;
`endif
    endfunction

    function automatic logic [5:0] exp_pix(input int l, input int p);
        logic [23:0] w;
        w = memw[(row_of(l) * WPL + p / PPW) % 1024];
        return w[BPP * (p % PPW) +: BPP];
    endfunction

    task automatic cycle(input int p, input int l);
        bit acc;
        bit drv;
        int bad_i;
        int got_a;
        logic [5:0] exp;
        pc = 10'(p);
        lc = 10'(l);
        case (rdy_mode)
            0: req_ready = 1'b1;
            1: req_ready = (cyc_n % 2 == 0);
            default: req_ready = ($urandom_range(0, 3) != 0);
        endcase
        drv = !mem_stall && pend_due.size() > 0 && pend_due[0] <= cyc_n;
        rsp_valid = drv;
        rsp_data = drv ? memw[pend_addr[0] % 1024] : 24'($urandom);
        @(negedge clk);
        acc = (req_valid === 1'b1) && req_ready;
        if (!rst && prev_stall && prev_pc != HACT) begin
            checks++;
            if (req_valid !== 1'b1 || req_addr !== prev_addr) begin
                failures++;
                $display("FAIL addr_hold: valid=%b addr=%0d required valid=1 addr=%0d",
                         req_valid, req_addr, prev_addr);
            end
        end
        prev_stall = (req_valid === 1'b1) && !req_ready;
        prev_addr = req_addr;
        prev_pc = p;
        @(posedge clk);
        cyc_n++;
        if (drv) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (acc && !rst) begin
            pend_addr.push_back(int'(req_addr));
            pend_due.push_back(cyc_n + 1);
            req_list.push_back(int'(req_addr));
            line_acc++;
        end
        if (p < HACT && l < VACT && p % PPW == 0) line_pops++;
        #1;
        exp = (p < HACT && l < VACT && !zero_mode) ? exp_pix(l, p) : 6'd0;
        checks++;
        if (pix !== exp) begin
            failures++;
            $display("FAIL pixel line %0d px %0d: got %0d required %0d", l, p, pix, exp);
        end
        checks++;
        if (line_acc - line_pops > DEPTH) begin
            failures++;
            $display("FAIL credit line %0d px %0d: words held %0d required <= %0d",
                     l, p, line_acc - line_pops, DEPTH);
        end
        if (p == HACT) begin
            if (chk_addr && l < VACT) begin
                bad_i = -1;
                for (int i = 0; i < WPL; i++)
                    if (bad_i < 0 && (i >= req_list.size() || req_list[i] != row_of(l) * WPL + i))
                        bad_i = i;
                got_a = (bad_i >= 0 && bad_i < req_list.size()) ? req_list[bad_i] : -1;
                checks++;
                if (bad_i >= 0 || req_list.size() != WPL) begin
                    failures++;
                    $display("FAIL req_addrs line %0d: got %0d words, bad idx %0d addr %0d; required %0d words %0d..%0d",
                             l, req_list.size(), bad_i, got_a, WPL,
                             row_of(l) * WPL, row_of(l) * WPL + WPL - 1);
                end
            end
            req_list.delete();
            line_acc = 0;
            line_pops = 0;
        end
    endtask

    task automatic seg(input int l, input int p0, input int p1);
        for (int p = p0; p <= p1; p++) cycle(p, l);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(HACT, 524);
            checks++;
            if (req_valid !== 1'b0 || pix !== 6'd0 || unf !== 1'b0 || req_addr !== 17'd0) begin
                failures++;
                $display("FAIL reset cyc %0d: valid=%b pix=%0d unf=%b addr=%0d required 0 0 0 0",
                         i, req_valid, pix, unf, req_addr);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch_display();
        seg(524, HACT, 799);
        seg(0, 0, HACT - 1);
        checks++;
        if (unf !== 1'b0) begin
            failures++;
            $display("FAIL underflow_line0: got %b required 0", unf);
        end
    endtask

    task automatic test_backpressure();
        rdy_mode = 1;
        seg(0, HACT, 799);
        seg(1, 0, HACT);
        checks++;
        if (unf !== 1'b0) begin
            failures++;
            $display("FAIL underflow_bp: got %b required 0", unf);
        end
    endtask

    task automatic test_line_map();
        rdy_mode = 2;
        seg(1, HACT + 1, 799);
        seg(2, 0, 799);
        seg(3, 0, 799);
        checks++;
        if (unf !== 1'b0) begin
            failures++;
            $display("FAIL underflow_map: got %b required 0", unf);
        end
    endtask

    task automatic test_underflow();
        pend_addr.delete();
        pend_due.delete();
        rdy_mode = 0;
        rst = 1'b1;
        cycle(0, 600);
        cycle(0, 600);
        rst = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        req_list.delete();
        line_acc = 0;
        line_pops = 0;
        prev_stall = 0;
        mem_stall = 1;
        chk_addr = 0;
        seg(524, HACT, 799);
        checks++;
        if (unf !== 1'b0) begin
            failures++;
            $display("FAIL underflow_pre: got %b required 0", unf);
        end
        zero_mode = 1;
        cycle(0, 0);
        checks++;
        if (unf !== 1'b1) begin
            failures++;
            $display("FAIL underflow_set: got %b required 1", unf);
        end
        seg(0, 1, HACT);
        zero_mode = 0;
        mem_stall = 0;
        chk_addr = 1;
        seg(0, HACT + 1, 799);
        seg(1, 0, 799);
        checks++;
        if (unf !== 1'b1) begin
            failures++;
            $display("FAIL underflow_sticky: got %b required 1", unf);
        end
    endtask

    initial begin
        rst = 1'b1;
        pc = '0;
        lc = '0;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_data = '0;
        for (int i = 0; i < 1024; i++) memw[i] = 24'($urandom);
        test_reset();
        test_fetch_display();
        test_backpressure();
        test_line_map();
        test_underflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
